// File: rtl/alu_pkg.sv
// ALU opcode encoding, opcode legality check and the arbiter FSM state type
// shared by the ALU and the requester-sharing wrapper.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_COPYB = 4'd10;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  function automatic logic alu_op_legal(input logic [3:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
      ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_COPYB: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU; set-less-than results come from the externally
// supplied branch compare i_BrLT.
module alu
  import alu_pkg::*;
(
  input  logic [3:0]  i_alu_op,
  input  logic [31:0] i_op_a,
  input  logic [31:0] i_op_b,
  input  logic        i_BrLT,
  output logic [31:0] o_alu_data
);

  logic [4:0] shamt;
  assign shamt = i_op_b[4:0];

  always_comb begin
    o_alu_data = '0;
    case (i_alu_op)
      ALU_ADD:           o_alu_data = i_op_a + i_op_b;
      ALU_SUB:           o_alu_data = i_op_a - i_op_b;
      ALU_SLL:           o_alu_data = i_op_a << shamt;
      ALU_SLT, ALU_SLTU: o_alu_data = {31'b0, i_BrLT};
      ALU_XOR:           o_alu_data = i_op_a ^ i_op_b;
      ALU_SRL:           o_alu_data = i_op_a >> shamt;
      ALU_SRA:           o_alu_data = $signed(i_op_a) >>> shamt;
      ALU_OR:            o_alu_data = i_op_a | i_op_b;
      ALU_AND:           o_alu_data = i_op_a & i_op_b;
      ALU_COPYB:         o_alu_data = i_op_b;
      default:           o_alu_data = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arb_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found searching
// upward from ptr_i+1 with wraparound; no grant when en_i is low.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    if (en_i) begin
      for (int unsigned i = 1; i <= N; i++) begin
        idx = IW'((32'(ptr_i) + i) % N);
        if (!found && req_i[idx]) begin
          found      = 1'b1;
          gnt_o[idx] = 1'b1;
          gnt_idx_o  = idx;
        end
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU between NREQ requesters: round-robin accept, one execute cycle
// from latched operands, then a held, ID-tagged response until consumed.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NREQ-1:0]       i_req_valid,
  output logic [NREQ-1:0]       o_req_ready,
  input  logic [NREQ-1:0][31:0] i_req_op_a,
  input  logic [NREQ-1:0][31:0] i_req_op_b,
  input  logic [NREQ-1:0][3:0]  i_req_alu_op,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [31:0]           o_rsp_data,
  output logic [IDW-1:0]        o_rsp_id,
  output logic                  o_rsp_err,
  output logic                  o_busy
);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [31:0]    op_a_q, op_a_d;
  logic [31:0]    op_b_q, op_b_d;
  logic [3:0]     alu_op_q, alu_op_d;
  logic [31:0]    rsp_data_q, rsp_data_d;
  logic           rsp_err_q, rsp_err_d;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            arb_en;
  logic            accept;
  logic            br_lt;
  logic [31:0]     alu_data;

  assign arb_en = (state_q == ARB_IDLE);

  rr_arbiter #(
    .N(NREQ)
  ) u_rr_arbiter (
    .req_i    (i_req_valid),
    .ptr_i    (rr_ptr_q),
    .en_i     (arb_en),
    .gnt_o    (gnt),
    .gnt_idx_o(gnt_idx)
  );

  // The arbiter only grants valid requesters, so a grant is a handshake.
  assign accept = |gnt;

  always_comb begin
    br_lt = 1'b0;
    if (alu_op_q == ALU_SLT) begin
      br_lt = $signed(op_a_q) < $signed(op_b_q);
    end else if (alu_op_q == ALU_SLTU) begin
      br_lt = op_a_q < op_b_q;
    end
  end

  alu u_alu (
    .i_alu_op  (alu_op_q),
    .i_op_a    (op_a_q),
    .i_op_b    (op_b_q),
    .i_BrLT    (br_lt),
    .o_alu_data(alu_data)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (accept) state_d = ARB_EXEC;
      ARB_EXEC: state_d = ARB_RESP;
      ARB_RESP: if (i_rsp_ready) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = '0;
    o_rsp_valid = 1'b0;
    o_busy      = 1'b0;
    case (state_q)
      // Gate with reset so every output reads 0 while reset is held.
      ARB_IDLE: if (!i_rst) o_req_ready = gnt;
      ARB_EXEC: o_busy = 1'b1;
      ARB_RESP: begin
        o_rsp_valid = 1'b1;
        o_busy      = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    rsp_id_d   = rsp_id_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    alu_op_d   = alu_op_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    if (accept) begin
      op_a_d   = i_req_op_a[gnt_idx];
      op_b_d   = i_req_op_b[gnt_idx];
      alu_op_d = i_req_alu_op[gnt_idx];
      rsp_id_d = gnt_idx;
      rr_ptr_d = gnt_idx;
    end
    if (state_q == ARB_EXEC) begin
      rsp_err_d  = !alu_op_legal(alu_op_q);
      rsp_data_d = rsp_err_d ? '0 : alu_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_ptr_q   <= IDW'(NREQ - 1);
      rsp_id_q   <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      alu_op_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rsp_id_q   <= rsp_id_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      alu_op_q   <= alu_op_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign o_rsp_data = rsp_data_q;
  assign o_rsp_id   = rsp_id_q;
  assign o_rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: vector table of single-requester ops plus
// round-robin, backpressure and reset-during-execute sequences.
module tb_alu_share_arb;
  import alu_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][31:0] req_op_a;
  logic [NREQ-1:0][31:0] req_op_b;
  logic [NREQ-1:0][3:0]  req_alu_op;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_data;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_err;
  logic                  busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_share_arb #(
    .NREQ(NREQ)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_op_a  (req_op_a),
    .i_req_op_b  (req_op_b),
    .i_req_alu_op(req_alu_op),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data),
    .o_rsp_id    (rsp_id),
    .o_rsp_err   (rsp_err),
    .o_busy      (busy)
  );

  typedef struct {
    int unsigned req;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic        err;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One complete transaction from a single requester with exact cycle timing.
  task automatic run_op(input int unsigned req, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_data,
                        input logic exp_err);
    @(negedge clk);
    req_valid[req]  = 1'b1;
    req_op_a[req]   = a;
    req_op_b[req]   = b;
    req_alu_op[req] = op;
    #1 check("idle_ready", 32'(req_ready), 32'(1) << req);
    @(negedge clk);
    req_valid[req] = 1'b0;
    #1 check("exec_ready", 32'(req_ready), 32'd0);
    check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    check("exec_busy", 32'(busy), 32'd1);
    @(negedge clk);
    #1 check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_data", rsp_data, exp_data);
    check("rsp_id", 32'(rsp_id), 32'(req));
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1 check("after_rsp_valid", 32'(rsp_valid), 32'd0);
    check("after_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1, ALU_ADD,  32'd5,        32'd7,        32'd12,       1'b0};
    vecs[1]  = '{0, ALU_SLT,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b0};
    vecs[2]  = '{2, ALU_SLTU, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0};
    vecs[3]  = '{3, ALU_SRA,  32'h80000000, 32'd4,        32'hF8000000, 1'b0};
    vecs[4]  = '{0, ALU_SRL,  32'h80000000, 32'd4,        32'h08000000, 1'b0};
    vecs[5]  = '{1, ALU_SUB,  32'd3,        32'd5,        32'hFFFFFFFE, 1'b0};
    vecs[6]  = '{2, ALU_SLL,  32'd1,        32'h24,       32'h10,       1'b0};
    vecs[7]  = '{3, 4'hF,     32'd5,        32'd7,        32'd0,        1'b1};
    vecs[8]  = '{0, ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0};
    vecs[9]  = '{1, ALU_OR,   32'h0F,       32'hF0,       32'hFF,       1'b0};
    vecs[10] = '{2, ALU_AND,  32'h0F,       32'h3C,       32'h0C,       1'b0};
    vecs[11] = '{3, ALU_SLT,  32'd1,        32'hFFFFFFFF, 32'd0,        1'b0};

    rst        = 1'b1;
    req_valid  = '0;
    req_op_a   = '0;
    req_op_b   = '0;
    req_alu_op = '0;
    rsp_ready  = 1'b0;

    #1 check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_data", rsp_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // All requesters valid after reset: grants 0,1,2,3 then back to 0.
    @(negedge clk);
    for (int r = 0; r < NREQ; r++) begin
      req_valid[r]  = 1'b1;
      req_op_a[r]   = 32'(r);
      req_op_b[r]   = 32'd100;
      req_alu_op[r] = ALU_ADD;
    end
    #1;
    for (int k = 0; k < 5; k++) begin
      check("rr_grant", 32'(req_ready), 32'(1) << (k % NREQ));
      @(negedge clk);
      #1 check("rr_exec_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      #1 check("rr_rsp_id", 32'(rsp_id), 32'(k % NREQ));
      check("rr_rsp_data", rsp_data, 32'd100 + 32'(k % NREQ));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
    end
    req_valid = '0;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].req, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].data, vecs[i].err);
    end

    // Backpressure: response held for 5 cycles while others wait.
    @(negedge clk);
    req_valid[2]  = 1'b1;
    req_op_a[2]   = 32'd10;
    req_op_b[2]   = 32'd20;
    req_alu_op[2] = ALU_ADD;
    @(negedge clk);
    req_valid[2] = 1'b0;
    req_valid[0] = 1'b1;
    req_valid[3] = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1 check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data", rsp_data, 32'd30);
      check("bp_id", 32'(rsp_id), 32'd2);
      check("bp_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1 check("bp_ready_cycle_grant", 32'(req_ready), 32'd0);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1 check("bp_next_grant", 32'(req_ready), 32'b1000);
    req_valid = '0;
    @(negedge clk);
    #1 check("bp_dropped_busy", 32'(busy), 32'd0);
    check("bp_dropped_ready", 32'(req_ready), 32'd0);

    // Reset asserted during EXEC.
    req_valid[2]  = 1'b1;
    req_op_a[2]   = 32'd1;
    req_op_b[2]   = 32'd2;
    req_alu_op[2] = ALU_ADD;
    @(negedge clk);
    req_valid[2] = 1'b0;
    req_valid[3] = 1'b1;
    #1 check("mid_exec_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1 check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    check("mid_rst_data", rsp_data, 32'd0);
    check("mid_rst_id", 32'(rsp_id), 32'd0);
    @(negedge clk);
    rst          = 1'b0;
    req_valid[3] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1 check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    req_valid = '1;
    #1 check("post_rst_grant", 32'(req_ready), 32'd1);
    req_valid = '0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
